sys_arr_feeder: RTL and testbench
=================================

# sys_arr_feeder

Upstream operand feeder for the output-stationary systolic matrix-multiply array of `mat_acc` processing elements. Buffers one N×N tile of A (column-wise) and B (row-wise), loaded through a valid/ready handshake. Injects operands into the array's left edge (A rows) and top edge (B columns) with the diagonal skew the array requires, so that PE(i,j) sees A[i][k] and B[k][j] in the same cycle. Sequences a per-tile accumulator clear before streaming and a completion pulse after the last partial product has reached PE(N-1,N-1).

## Interface
Parameters:
- `N`, 4, array dimension (rows = cols = reduction depth); N ≥ 2
- `W`, 8, operand width in bits

Ports:
- `CLK`  in  1  clock; reset rst, synchronous, active-high; clock CLK
- `rst`  in  1  synchronous active-high reset
- `in_vld`  in  1  load beat valid
- `in_rdy`  out  1  feeder accepts a load beat
- `in_a`  in  N*W  A column k: lane i = A[i][k]
- `in_b`  in  N*W  B row k: lane j = B[k][j]
- `arr_rdy`  in  1  array/collector permits advance; 0 = stall
- `a_edge`  out  N*W  lane i drives array row i `a` input
- `b_edge`  out  N*W  lane j drives array column j `b` input
- `edge_vld`  out  1  edge lanes carry a live step
- `acc_clr`  out  1  one-cycle clear to all PE accumulators
- `done`  out  1  one-cycle pulse: tile result final in array

## Operation
- FSM states: LOAD, CLEAR, STREAM, DONE.
- LOAD: `in_rdy`=1. Each beat with `in_vld`&&`in_rdy` writes column/row buffers at index k = load counter, k increments. On the N-th beat → CLEAR.
- CLEAR: `acc_clr`=1 for exactly one cycle, `in_rdy`=0 → STREAM with step counter t=0.
- STREAM: t runs 0 … 3N-3 (3N-2 steps). Advances only when `arr_rdy`=1.
  - Lane i of `a_edge` = A[i][t-i] when 0 ≤ t-i < N, else 0.
  - Lane j of `b_edge` = B[t-j][j] when 0 ≤ t-j < N, else 0.
  - Steps 2N-1 … 3N-3 are all-zero drain steps, letting operands propagate to the far corner.
  - On `arr_rdy`=0: `a_edge`=`b_edge`=0 and `edge_vld`=0; t holds. Zero operands leave every PE accumulator unchanged, so the array needs no enable.
  - On the last step accepted → DONE.
- DONE: `done`=1 for one cycle → LOAD, with the load counter at 0. Buffers are not cleared; they are overwritten by the next tile.
- Arithmetic: no arithmetic on operands. Counters are unsigned, width $clog2(3N). Lane index math is evaluated on integer-extended values, so negative t-i selects 0.

## Timing
- Reset values: state=LOAD, counters=0, `in_rdy`=1 (the cycle after rst deasserts), `a_edge`=`b_edge`=0, `edge_vld`=0, `acc_clr`=0, `done`=0.
- Outputs `a_edge`, `b_edge`, `edge_vld`, `acc_clr`, `done` are registered.
- `in_rdy` is a combinational decode of the state.
- Last load beat accepted at cycle c → `acc_clr` high at c+1 → first STREAM step (t=0) at c+2.
- Without stalls, `done` is high at c+2+(3N-2) = c+3N. Each stall cycle adds one cycle.
- `in_vld` outside LOAD is ignored; no beat is consumed.
- rst asserted mid-STREAM: the next cycle is reset state, with zero edges and no `done`. The partial tile is discarded.
- `arr_rdy` is sampled only in STREAM. CLEAR and DONE never stall.

## Structure
- Shared package `sys_arr_pkg`: `N`/`W` default constants, state enum `feed_state_t`, and `operand_t` = logic [W-1:0].
- One sub-module `skew_mux`: per-lane selection of buffer[idx] or 0, given t and the lane index. It is instantiated N times for the A lanes and N times for the B lanes.
- Buffers are N×N register arrays; no SRAM.

## Test plan
- Identity tile, N=4, W=8: load A=I and B[k][j]=k*4+j+1. Check the `a_edge` lane 0 sequence 1,0,0,0,0,0,0,0,0,0, and that `b_edge` lane 3 carries 4,8,12,16 at t=3..6. Check `done` at c+12.
- Skew check with all-ones A and B: at t=0 only lane 0 is nonzero; at t=3 all lanes are 1; at t=6 only lane 3 is 1; t=7..9 are all zeros.
- Load backpressure: deassert `in_vld` between beats. Exactly 4 beats are accepted and `acc_clr` pulses once. `in_rdy`=0 from CLEAR through DONE.
- Stall: hold `arr_rdy`=0 for 3 cycles at t=2. Edges are 0 and `edge_vld`=0 during the stall, the t=2 values reappear afterwards, and `done` is delayed by exactly 3 cycles.
- Reset mid-STREAM at t=4: outputs are zero the next cycle, `in_rdy`=1, and a fresh tile loads and streams correctly.
- End-to-end with a 4×4 `mat_acc` array: A[i][k]=i+1, B[k][j]=1. At `done`, PE(i,j)=4(i+1) mod 256.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// rtl/sys_arr_pkg.sv - shared types and defaults for the systolic array feeder
// Purpose: default array geometry, feeder state encoding and operand type.
// Ports: none (package).
package sys_arr_pkg;

  localparam int N_DEF = 4;  // array dimension (rows = cols = reduction depth)
  localparam int W_DEF = 8;  // operand width in bits

  typedef enum logic [1:0] {
    LOAD,
    CLEAR,
    STREAM,
    DONE
  } feed_state_t;

  typedef logic [W_DEF-1:0] operand_t;

endpackage

// File: rtl/sys_arr_feeder_skew_mux.sv
// rtl/sys_arr_feeder_skew_mux.sv - per-lane diagonal skew operand select
// Purpose: lane LANE presents ops[t-LANE] while 0 <= t-LANE < N, otherwise 0.
// Ports:
//   t    in   step counter
//   ops  in   N operands of this lane, indexed by reduction step k
//   val  out  operand for this lane at step t
module skew_mux
  import sys_arr_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = W_DEF,
  parameter int LANE = 0,
  parameter int CW   = $clog2(3 * N)
) (
  input  logic [CW-1:0] t,
  input  logic [W-1:0]  ops [N],
  output logic [W-1:0]  val
);

  // Compare on integer-extended values so steps before the lane's start
  // (negative t-LANE) and after its end simply match no k and yield 0.
  always_comb begin
    val = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(t) == LANE + k) val = ops[k];
    end
  end

endmodule

// File: rtl/sys_arr_feeder.sv
// rtl/sys_arr_feeder.sv - tile buffer and skewed edge feeder for the systolic array
// Purpose: loads one NxN tile (A by column, B by row), clears the PE
// accumulators, streams skewed operands into the array edges and pulses done.
// Ports:
//   CLK, rst  clock; synchronous active-high reset
//   in_vld    in   load beat valid
//   in_rdy    out  feeder accepts a load beat (LOAD state)
//   in_a      in   A column k, lane i = A[i][k]
//   in_b      in   B row k, lane j = B[k][j]
//   arr_rdy   in   array permits advance; 0 inserts a zero step
//   a_edge    out  lane i drives array row i
//   b_edge    out  lane j drives array column j
//   edge_vld  out  edge lanes carry a live step
//   acc_clr   out  one-cycle accumulator clear
//   done      out  one-cycle tile-complete pulse
module sys_arr_feeder
  import sys_arr_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  input  logic           arr_rdy,
  output logic [N*W-1:0] a_edge,
  output logic [N*W-1:0] b_edge,
  output logic           edge_vld,
  output logic           acc_clr,
  output logic           done
);

  localparam int CW = $clog2(3 * N);
  localparam logic [CW-1:0] LAST_K  = CW'(N - 1);
  // t counts the next step to launch; 3N-2 means every step has been launched.
  localparam logic [CW-1:0] DRAINED = CW'(3 * N - 2);

  feed_state_t    state, state_nxt;
  logic [CW-1:0]  k_cnt, k_nxt;
  logic [CW-1:0]  t_cnt, t_nxt;
  logic           push, wr, acc_clr_nxt, done_nxt;
  logic [N*W-1:0] a_sel, b_sel;

  // Both buffers are stored lane-major so each lane's mux sees its own row:
  // a_buf[i][k] = A[i][k], bt_buf[j][k] = B[k][j].
  logic [W-1:0] a_buf  [N][N];
  logic [W-1:0] bt_buf [N][N];

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= LOAD;
      k_cnt    <= '0;
      t_cnt    <= '0;
      a_edge   <= '0;
      b_edge   <= '0;
      edge_vld <= 1'b0;
      acc_clr  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      k_cnt    <= k_nxt;
      t_cnt    <= t_nxt;
      a_edge   <= push ? a_sel : '0;
      b_edge   <= push ? b_sel : '0;
      edge_vld <= push;
      acc_clr  <= acc_clr_nxt;
      done     <= done_nxt;
    end
  end

  // Edge registers are loaded one cycle ahead of the step they show, so CLEAR
  // launches step 0 (it never stalls) and STREAM launches steps 1..3N-3 only
  // while arr_rdy is high; a refused cycle shows an all-zero step instead.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k_cnt;
    t_nxt       = t_cnt;
    push        = 1'b0;
    wr          = 1'b0;
    acc_clr_nxt = 1'b0;
    done_nxt    = 1'b0;
    in_rdy      = 1'b0;
    case (state)
      LOAD: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          wr = 1'b1;
          if (k_cnt == LAST_K) begin
            k_nxt       = '0;
            state_nxt   = CLEAR;
            acc_clr_nxt = 1'b1;
          end else begin
            k_nxt = k_cnt + CW'(1);
          end
        end
      end
      CLEAR: begin
        push      = 1'b1;
        t_nxt     = CW'(1);
        state_nxt = STREAM;
      end
      STREAM: begin
        if (t_cnt == DRAINED) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (arr_rdy) begin
          push  = 1'b1;
          t_nxt = t_cnt + CW'(1);
        end
      end
      DONE: begin
        t_nxt     = '0;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr && !rst) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (k_cnt == CW'(k)) begin
            a_buf[i][k]  <= in_a[i*W +: W];
            bt_buf[i][k] <= in_b[i*W +: W];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_mux #(.N(N), .W(W), .LANE(g), .CW(CW)) u_a_mux (
      .t   (t_cnt),
      .ops (a_buf[g]),
      .val (a_sel[g*W +: W])
    );
    skew_mux #(.N(N), .W(W), .LANE(g), .CW(CW)) u_b_mux (
      .t   (t_cnt),
      .ops (bt_buf[g]),
      .val (b_sel[g*W +: W])
    );
  end

endmodule

// File: tb/tb_sys_arr_feeder.sv
// tb/tb_sys_arr_feeder.sv - scoreboard bench for sys_arr_feeder
module tb_sys_arr_feeder;
  import sys_arr_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK, rst, in_vld, in_rdy, arr_rdy, edge_vld, acc_clr, done;
  logic [N*W-1:0] in_a, in_b, a_edge, b_edge;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_on = 0;

  operand_t ta [N][N];
  operand_t tb [N][N];

  logic [2*N*W-1:0] step_q [$];
  int               clr_q  [$];
  int               done_q [$];
  int               c_q    [$];
  logic [N*W-1:0]   ha [$];
  logic [N*W-1:0]   hb [$];

  sys_arr_feeder #(.N(N), .W(W)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_a     (in_a),
    .in_b     (in_b),
    .arr_rdy  (arr_rdy),
    .a_edge   (a_edge),
    .b_edge   (b_edge),
    .edge_vld (edge_vld),
    .acc_clr  (acc_clr),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with no expectation pending (cycle %0d)", nm, cyc);
  endtask

  // Reference array: a PE(i,j) sees a from lane i delayed by j steps and b from
  // lane j delayed by i steps; the result must equal the plain matrix product.
  task automatic check_products();
    logic [N*W-1:0] va, vb;
    int sum, ai, bi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int s = 0; s < ha.size() + 2 * N; s++) begin
          ai = s - j;
          bi = s - i;
          if (ai >= 0 && ai < ha.size() && bi >= 0 && bi < hb.size()) begin
            va = ha[ai];
            vb = hb[bi];
            sum += int'(va[i*W +: W]) * int'(vb[j*W +: W]);
          end
        end
        if (c_q.size() == 0) miss("pe_result");
        else chk($sformatf("pe_result[%0d][%0d]", i, j), sum, c_q.pop_front());
      end
    end
  endtask

  always @(negedge CLK) begin
    if (mon_on) begin
      if (edge_vld) begin
        if (step_q.size() == 0) miss("edge_step");
        else chk("edge_step", {a_edge, b_edge}, step_q.pop_front());
        ha.push_back(a_edge);
        hb.push_back(b_edge);
      end else begin
        chk("edge_idle_zero", {a_edge, b_edge}, '0);
      end
      if (acc_clr) begin
        if (clr_q.size() == 0) miss("acc_clr_cycle");
        else chk("acc_clr_cycle", cyc, clr_q.pop_front());
        ha.delete();
        hb.delete();
      end
      if (done) begin
        if (done_q.size() == 0) miss("done_cycle");
        else begin
          chk("done_cycle", cyc, done_q.pop_front());
          check_products();
        end
      end
    end
  end

  task automatic set_tile(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (mode)
          0: begin ta[i][j] = (i == j) ? 8'd1 : 8'd0; tb[i][j] = operand_t'(i * 4 + j + 1); end
          1: begin ta[i][j] = 8'd1; tb[i][j] = 8'd1; end
          3: begin ta[i][j] = operand_t'(i + 1); tb[i][j] = 8'd1; end
          default: begin ta[i][j] = operand_t'($urandom); tb[i][j] = operand_t'($urandom); end
        endcase
      end
    end
  endtask

  // Loads the current tile with random in_vld gaps, pushes the expected
  // stream, then drives arr_rdy per a pre-planned pattern until done.
  task automatic run_tile(input int stall_at, input int stall_len, input int rst_at, input bit rnd_rdy);
    int k, c, guard, x, done_cyc, pending, sum;
    bit acc, b;
    bit pat [$];
    logic [N*W-1:0] ea, eb;
    k = 0; c = 0; guard = 0; done_cyc = 0;
    while (k < N && guard < 200) begin
      in_vld = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        in_a[i*W +: W] = ta[i][k];
        in_b[i*W +: W] = tb[k][i];
      end
      arr_rdy = 1'($urandom_range(0, 1));
      acc = in_vld && in_rdy;
      if (acc && k == N - 1) begin
        c = cyc;
        for (int s = 0; s <= 3 * N - 3; s++) begin
          ea = '0; eb = '0;
          for (int i = 0; i < N; i++) begin
            if (s - i >= 0 && s - i < N) begin
              ea[i*W +: W] = ta[i][s-i];
              eb[i*W +: W] = tb[s-i][i];
            end
          end
          step_q.push_back({ea, eb});
        end
        clr_q.push_back(c + 1);
        pending = 3 * N - 3;
        x = 0;
        while (pending > 0 && x < 200) begin
          if (x >= stall_at && x < stall_at + stall_len) b = 1'b0;
          else if (rnd_rdy) b = ($urandom_range(0, 3) != 0);
          else b = 1'b1;
          pat.push_back(b);
          if (b) pending--;
          x++;
        end
        done_cyc = c + 2 + x + 1;
        done_q.push_back(done_cyc);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            sum = 0;
            for (int kk = 0; kk < N; kk++) sum += int'(ta[i][kk]) * int'(tb[kk][j]);
            c_q.push_back(sum);
          end
      end
      @(posedge CLK); #1;
      if (acc) k++;
      guard++;
    end
    if (k < N) begin
      chk("load_beats", k, N);
      return;
    end
    for (int cy = c + 1; cy <= done_cyc; cy++) begin
      in_vld = 1'($urandom_range(0, 1));
      in_a = $urandom;
      in_b = $urandom;
      x = cy - (c + 2);
      if (x >= 0 && x < pat.size()) arr_rdy = pat[x];
      else arr_rdy = 1'($urandom_range(0, 1));
      if (x == rst_at) rst = 1'b1;
      chk("in_rdy_busy", in_rdy, 0);
      @(posedge CLK); #1;
      if (rst) begin
        rst = 1'b0;
        step_q.delete();
        done_q.delete();
        c_q.delete();
        chk("rst_mid_edges", {a_edge, b_edge}, '0);
        chk("rst_mid_ctrl", {edge_vld, acc_clr, done}, '0);
        chk("rst_mid_in_rdy", in_rdy, 1);
        return;
      end
    end
    chk("in_rdy_after_done", in_rdy, 1);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_a = '0; in_b = '0; arr_rdy = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    chk("reset_edges", {a_edge, b_edge}, '0);
    chk("reset_ctrl", {edge_vld, acc_clr, done}, '0);
    chk("reset_in_rdy", in_rdy, 1);
    mon_on = 1'b1;

    set_tile(0); run_tile(-1, 0, -1, 1'b0);   // identity A, B[k][j]=4k+j+1
    set_tile(1); run_tile(-1, 0, -1, 1'b0);   // all-ones skew shape
    set_tile(2); run_tile(1, 3, -1, 1'b0);    // 3-cycle stall before step 2
    set_tile(2); run_tile(-1, 0, 4, 1'b0);    // reset while step 4 is on the edges
    set_tile(3); run_tile(-1, 0, -1, 1'b0);   // A[i][k]=i+1, B=1 after the reset
    for (int n = 0; n < 6; n++) begin
      set_tile(2);
      run_tile(-1, 0, -1, 1'b1);
    end

    in_vld = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("steps_left", step_q.size(), 0);
    chk("clr_left", clr_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
